wr_en_generator: RTL and testbench

Writeback-stage write-enable gate for the integer register file and the CSR file. It forwards the pipelined write-enable requests, rf_wr_en_reg_in and csr_wr_en_reg_in, and forces both enables low while a pipeline flush is active. It also counts writes squashed by flush, for debug and performance visibility. It sits between the MEM/WB pipeline register and the register-file and CSR-file write ports.

---
 rtl/wr_en_generator_pkg.sv | 17 +
 rtl/wr_en_sat_counter.sv | 32 +++
 rtl/wr_en_generator.sv | 74 +++++++
 tb/tb_wr_en_generator.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/wr_en_generator_pkg.sv
// Shared helpers for the writeback write-enable gate.
package wr_en_generator_pkg;

  // Reset value for enable flops and counters.
  localparam logic EN_OFF = 1'b0;

  // A write request survives only when no flush is active.
  function automatic logic gate_en(input logic req, input logic flush);
    return req & ~flush;
  endfunction

  // A write request is squashed when a flush is active.
  function automatic logic squashed(input logic req, input logic flush);
    return req & flush;
  endfunction

endpackage

// File: rtl/wr_en_sat_counter.sv
// Saturating event counter with synchronous clear and async reset.
module wr_en_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             clr_in,
  input  logic             inc_in,
  output logic [CNT_W-1:0] cnt_out
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  logic [CNT_W-1:0] cnt_r;

  // Count increments, holding at all-ones; clear wins over increment.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr_in) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (inc_in && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt_out = cnt_r;

endmodule

// File: rtl/wr_en_generator.sv
// Writeback write-enable gate for the register and CSR files, with
// flush-squash counters for debug visibility.
module wr_en_generator
  import wr_en_generator_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter bit REG_OUT = 1'b0
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             flush_in,
  input  logic             rf_wr_en_reg_in,
  input  logic             csr_wr_en_reg_in,
  input  logic             cnt_clr_in,
  output logic             wr_en_int_file_out,
  output logic             wr_en_csr_file_out,
  output logic [CNT_W-1:0] squash_int_cnt_out,
  output logic [CNT_W-1:0] squash_csr_cnt_out
);

  logic int_en_s;
  logic csr_en_s;
  logic int_sq_s;
  logic csr_sq_s;

  // Flush overrides both requests; squash strobes feed the counters.
  always_comb begin
    int_en_s = gate_en(rf_wr_en_reg_in, flush_in);
    csr_en_s = gate_en(csr_wr_en_reg_in, flush_in);
    int_sq_s = squashed(rf_wr_en_reg_in, flush_in);
    csr_sq_s = squashed(csr_wr_en_reg_in, flush_in);
  end

  generate
    if (REG_OUT) begin : g_reg_out
      logic int_en_r;
      logic csr_en_r;

      // Register the gated enables for a one-cycle-latency timing cut.
      always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
          int_en_r <= EN_OFF;
          csr_en_r <= EN_OFF;
        end else begin
          int_en_r <= int_en_s;
          csr_en_r <= csr_en_s;
        end
      end

      assign wr_en_int_file_out = int_en_r;
      assign wr_en_csr_file_out = csr_en_r;
    end else begin : g_comb_out
      assign wr_en_int_file_out = int_en_s;
      assign wr_en_csr_file_out = csr_en_s;
    end
  endgenerate

  wr_en_sat_counter #(.CNT_W(CNT_W)) u_int_cnt (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .clr_in   (cnt_clr_in),
    .inc_in   (int_sq_s),
    .cnt_out  (squash_int_cnt_out)
  );

  wr_en_sat_counter #(.CNT_W(CNT_W)) u_csr_cnt (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .clr_in   (cnt_clr_in),
    .inc_in   (csr_sq_s),
    .cnt_out  (squash_csr_cnt_out)
  );

endmodule

// File: tb/tb_wr_en_generator.sv
// Directed bench: A = combinational/16-bit, B = combinational/2-bit,
// C = registered/16-bit, all sharing one stimulus set.
module tb_wr_en_generator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic rf = 1'b0;
  logic csr = 1'b0;
  logic clr = 1'b0;

  logic        a_int, a_csr, b_int, b_csr, c_int, c_csr;
  logic [15:0] a_icnt, a_ccnt, c_icnt, c_ccnt;
  logic [1:0]  b_icnt, b_ccnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wr_en_generator #(.CNT_W(16), .REG_OUT(1'b0)) u_a (
    .clk_in(clk), .rst_n_in(rst_n), .flush_in(flush), .rf_wr_en_reg_in(rf),
    .csr_wr_en_reg_in(csr), .cnt_clr_in(clr), .wr_en_int_file_out(a_int),
    .wr_en_csr_file_out(a_csr), .squash_int_cnt_out(a_icnt), .squash_csr_cnt_out(a_ccnt));

  wr_en_generator #(.CNT_W(2), .REG_OUT(1'b0)) u_b (
    .clk_in(clk), .rst_n_in(rst_n), .flush_in(flush), .rf_wr_en_reg_in(rf),
    .csr_wr_en_reg_in(csr), .cnt_clr_in(clr), .wr_en_int_file_out(b_int),
    .wr_en_csr_file_out(b_csr), .squash_int_cnt_out(b_icnt), .squash_csr_cnt_out(b_ccnt));

  wr_en_generator #(.CNT_W(16), .REG_OUT(1'b1)) u_c (
    .clk_in(clk), .rst_n_in(rst_n), .flush_in(flush), .rf_wr_en_reg_in(rf),
    .csr_wr_en_reg_in(csr), .cnt_clr_in(clr), .wr_en_int_file_out(c_int),
    .wr_en_csr_file_out(c_csr), .squash_int_cnt_out(c_icnt), .squash_csr_cnt_out(c_ccnt));

  // Async reset pulse placed just after a falling edge, released there too.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    flush = 1'b0; rf = 1'b0; csr = 1'b0; clr = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({a_icnt, a_ccnt} !== 32'h0000_0000) begin
      failures++;
      $display("FAIL reset_cnt_a: got %h/%h want 0/0", a_icnt, a_ccnt);
    end
    checks++;
    if ({c_int, c_csr, c_icnt, c_ccnt} !== 34'h0) begin
      failures++;
      $display("FAIL reset_c: got int=%b csr=%b cnt=%h/%h want all 0", c_int, c_csr, c_icnt, c_ccnt);
    end
    checks++;
    if ({b_icnt, b_ccnt} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_cnt_b: got %b/%b want 0/0", b_icnt, b_ccnt);
    end
  endtask

  task automatic test_comb_flush();
    do_reset();
    @(negedge clk);
    rf = 1'b1; csr = 1'b0; flush = 1'b0;
    #1;
    checks++;
    if ({a_int, a_csr} !== 2'b10) begin
      failures++;
      $display("FAIL comb_pass: got %b%b want 10", a_int, a_csr);
    end
    flush = 1'b1;
    #1;
    checks++;
    if ({a_int, a_csr} !== 2'b00) begin
      failures++;
      $display("FAIL comb_flush_rf: got %b%b want 00", a_int, a_csr);
    end
    csr = 1'b1;
    #1;
    checks++;
    if ({a_int, a_csr} !== 2'b00) begin
      failures++;
      $display("FAIL comb_flush_both: got %b%b want 00", a_int, a_csr);
    end
    flush = 1'b0; rf = 1'b0; csr = 1'b0;
  endtask

  task automatic test_all_combos();
    logic [2:0] v;
    logic [1:0] exp_tab [8];
    exp_tab = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {flush, rf, csr} = v;
      #1;
      checks++;
      if ({a_int, a_csr} !== exp_tab[i]) begin
        failures++;
        $display("FAIL combo_a[%0d]: got %b%b want %b", i, a_int, a_csr, exp_tab[i]);
      end
      checks++;
      if ({b_int, b_csr} !== exp_tab[i]) begin
        failures++;
        $display("FAIL combo_b[%0d]: got %b%b want %b", i, b_int, b_csr, exp_tab[i]);
      end
    end
    flush = 1'b0; rf = 1'b0; csr = 1'b0;
  endtask

  task automatic test_counters();
    do_reset();
    @(negedge clk);
    flush = 1'b1; rf = 1'b1; csr = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (a_icnt !== 16'd5 || a_ccnt !== 16'd0) begin
      failures++;
      $display("FAIL cnt_five: got %0d/%0d want 5/0", a_icnt, a_ccnt);
    end
    checks++;
    if (b_icnt !== 2'd3) begin
      failures++;
      $display("FAIL cnt_b_int_sat: got %0d want 3", b_icnt);
    end
    clr = 1'b1;
    @(negedge clk);
    checks++;
    if (a_icnt !== 16'd0 || a_ccnt !== 16'd0) begin
      failures++;
      $display("FAIL cnt_clear: got %0d/%0d want 0/0", a_icnt, a_ccnt);
    end
    clr = 1'b0; flush = 1'b0; rf = 1'b0;
  endtask

  task automatic test_saturation_async_reset();
    do_reset();
    @(negedge clk);
    flush = 1'b1; rf = 1'b0; csr = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (b_ccnt !== 2'd3 || b_icnt !== 2'd0) begin
      failures++;
      $display("FAIL sat_b: got csr=%0d int=%0d want 3/0", b_ccnt, b_icnt);
    end
    checks++;
    if (a_ccnt !== 16'd6) begin
      failures++;
      $display("FAIL sat_a_wide: got %0d want 6", a_ccnt);
    end
    flush = 1'b0; rf = 1'b1; csr = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (b_ccnt !== 2'd0 || a_ccnt !== 16'd0) begin
      failures++;
      $display("FAIL async_rst_cnt: got b=%0d a=%0d want 0/0", b_ccnt, a_ccnt);
    end
    checks++;
    if ({a_int, a_csr} !== 2'b10) begin
      failures++;
      $display("FAIL comb_in_reset: got %b%b want 10", a_int, a_csr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rf = 1'b0;
  endtask

  task automatic test_registered();
    do_reset();
    @(negedge clk);
    flush = 1'b0; rf = 1'b1; csr = 1'b0;
    #1;
    checks++;
    if (c_int !== 1'b0) begin
      failures++;
      $display("FAIL reg_before_edge: got %b want 0", c_int);
    end
    @(posedge clk); #1;
    checks++;
    if ({c_int, c_csr} !== 2'b10) begin
      failures++;
      $display("FAIL reg_rise: got %b%b want 10", c_int, c_csr);
    end
    @(negedge clk);
    flush = 1'b1;
    #1;
    checks++;
    if (c_int !== 1'b1) begin
      failures++;
      $display("FAIL reg_hold: got %b want 1", c_int);
    end
    @(posedge clk); #1;
    checks++;
    if (c_int !== 1'b0) begin
      failures++;
      $display("FAIL reg_fall: got %b want 0", c_int);
    end
    @(negedge clk);
    flush = 1'b0; csr = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({c_int, c_csr} !== 2'b11) begin
      failures++;
      $display("FAIL reg_both: got %b%b want 11", c_int, c_csr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({c_int, c_csr} !== 2'b00) begin
      failures++;
      $display("FAIL reg_async_rst: got %b%b want 00", c_int, c_csr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rf = 1'b0; csr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_comb_flush();
    test_all_combos();
    test_counters();
    test_saturation_async_reset();
    test_registered();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
